// File: rtl/tr_rr_arb.sv
// Round-robin arbiter that grants one of N requesters access to a shared
// single-beat channel for a burst of len+1 beats. A burst ends when its last
// beat is acknowledged, when the owner withdraws its request, or when a beat
// waits TIMEOUT cycles without acknowledge (reported by a one-cycle err_o).
module tr_rr_arb #(
    parameter int unsigned N       = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned LW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] wdata_i,
    input  logic [N*LW-1:0] len_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    ack_o,
    output logic            err_o,
    output logic            busy_o,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic [DW-1:0]   rdata_o
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e          r_state;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   r_ptr;
    logic [N-1:0]    r_gnt;
    logic [LW-1:0]   r_beats;
    logic [WW-1:0]   r_wait;
    logic            r_err;

    logic [AW-1:0]   w_addr_arr  [N];
    logic [DW-1:0]   w_wdata_arr [N];
    logic [LW-1:0]   w_len_arr   [N];
    logic            w_any;
    logic [GW-1:0]   w_win;
    logic [N-1:0]    w_win_onehot;
    logic [GW-1:0]   w_next_ptr;
    logic            w_busy;
    logic            w_owner_req;
    logic            w_last_beat;
    logic            w_timeout;
    logic            w_exit;

    // Split the flattened per-requester buses into indexable arrays.
    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign w_addr_arr[k]  = addr_i[k*AW +: AW];
        assign w_wdata_arr[k] = wdata_i[k*DW +: DW];
        assign w_len_arr[k]   = len_i[k*LW +: LW];
    end

    // Winner search: first set request at or above ptr, wrapping modulo N.
    always_comb begin
        logic [GW-1:0] idx;
        w_any = 1'b0;
        w_win = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = GW'((32'(r_ptr) + i) % N);
            if (!w_any && req_i[idx]) begin
                w_any = 1'b1;
                w_win = idx;
            end
        end
    end

    // One-hot form of the winner, loaded into the grant register.
    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    // Burst termination conditions evaluated in BUSY.
    always_comb begin
        w_busy      = (r_state == StBusy);
        w_owner_req = req_i[r_g];
        w_last_beat = (r_beats == '0);
        w_next_ptr  = (r_g == LAST_IDX) ? '0 : r_g + 1'b1;
        // An acknowledged beat always completes; a withdrawn request beats a timeout.
        w_timeout   = w_busy && !m_ack && w_owner_req && (r_wait == WAIT_MAX);
        w_exit      = w_busy && (m_ack ? (w_last_beat || !w_owner_req)
                                       : (!w_owner_req || (r_wait == WAIT_MAX)));
    end

    // Arbitration FSM with its grant, pointer, beat and wait counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_g     <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_beats <= '0;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state <= StBusy;
                        r_g     <= w_win;
                        r_gnt   <= w_win_onehot;
                        r_beats <= w_len_arr[w_win];
                        r_wait  <= '0;
                    end
                end
                StBusy: begin
                    if (w_exit) begin
                        r_state <= StIdle;
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_beats <= '0;
                        r_wait  <= '0;
                    end else if (m_ack) begin
                        r_beats <= r_beats - 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // Shared channel follows the owner only while BUSY; everything else idles at 0.
    always_comb begin
        m_req   = w_busy;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        ack_o   = '0;
        if (w_busy) begin
            m_we       = we_i[r_g];
            m_addr     = w_addr_arr[r_g];
            m_wdata    = w_wdata_arr[r_g];
            ack_o[r_g] = m_ack;
        end
    end

    assign gnt_o   = r_gnt;
    assign err_o   = r_err;
    assign busy_o  = w_busy;
    assign rdata_o = m_rdata;

    // Structural invariants of the grant and state outputs.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt_o));
    a_gnt_busy    : assert property (@(posedge clk) disable iff (!resetn)
                                     (gnt_o != '0) == busy_o);

endmodule

// File: tb/tb_tr_rr_arb.sv
// Randomised and directed bench for tr_rr_arb against a transaction-level
// reference model of the arbitration rules.
module tb_tr_rr_arb;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LW      = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*LW-1:0] len;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    ack_o;
    logic            err_o;
    logic            busy_o;
    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_ack;
    logic [DW-1:0]   m_rdata;
    logic [DW-1:0]   rdata_o;

    logic [AW-1:0]   addr_a  [N];
    logic [DW-1:0]   wdata_a [N];
    logic [LW-1:0]   len_a   [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner (-1 when idle), beats left, cycles waited, pointer.
    int owner;
    int left;
    int waited;
    int ptr;
    bit merr;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign addr[k*AW +: AW]  = addr_a[k];
        assign wdata[k*DW +: DW] = wdata_a[k];
        assign len[k*LW +: LW]   = len_a[k];
    end

    tr_rr_arb #(
        .N(N), .AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .len_i(len), .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o),
        .busy_o(busy_o), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        owner  = -1;
        left   = 0;
        waited = 0;
        ptr    = 0;
        merr   = 1'b0;
    endfunction

    // One clock edge of the arbitration rules, using the inputs held this cycle.
    function automatic void m_advance();
        bit nerr = 1'b0;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (ptr + k) % N;
                if (owner < 0 && req[idx]) begin
                    owner  = idx;
                    left   = int'(len_a[idx]);
                    waited = 0;
                end
            end
        end else if (m_ack) begin
            if (!req[owner] || left == 0) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end else begin
                left   = left - 1;
                waited = 0;
            end
        end else if (!req[owner]) begin
            ptr   = (owner + 1) % N;
            owner = -1;
        end else if (waited == TIMEOUT - 1) begin
            nerr  = 1'b1;
            ptr   = (owner + 1) % N;
            owner = -1;
        end else begin
            waited = waited + 1;
        end
        merr = nerr;
    endfunction

    function automatic logic [107:0] exp_vec();
        logic [N-1:0]  g  = '0;
        logic [N-1:0]  a  = '0;
        logic          b  = (owner >= 0);
        logic          w  = 1'b0;
        logic [AW-1:0] ad = '0;
        logic [DW-1:0] wd = '0;
        if (b) begin
            g[owner] = 1'b1;
            a[owner] = m_ack;
            w        = we[owner];
            ad       = addr_a[owner];
            wd       = wdata_a[owner];
        end
        return {g, a, merr, b, b, w, ad, wd, m_rdata};
    endfunction

    function automatic logic [107:0] act_vec();
        return {gnt_o, ack_o, err_o, busy_o, m_req, m_we, m_addr, m_wdata, rdata_o};
    endfunction

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            addr_a[k]  = $urandom;
            wdata_a[k] = $urandom;
        end
        we      = 4'($urandom);
        m_rdata = $urandom;
    endtask

    task automatic set_len(input logic [3:0] l0, input logic [3:0] l1,
                           input logic [3:0] l2, input logic [3:0] l3);
        len_a[0] = l0;
        len_a[1] = l1;
        len_a[2] = l2;
        len_a[3] = l3;
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) m_advance();
        else m_reset();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req    = 4'hF;
        m_ack  = 1'b1;
        set_len(0, 0, 0, 0);
        rand_data();
        m_reset();
        #3;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({gnt_o, ack_o, err_o, busy_o, m_req, m_we, m_addr, m_wdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c=%0d: got gnt=%b ack=%b err=%b busy=%b req=%b we=%b addr=%h wdata=%h want all zero",
                         c, gnt_o, ack_o, err_o, busy_o, m_req, m_we, m_addr, m_wdata);
            end
            n_tests++;
            if (rdata_o !== m_rdata) begin
                n_fail++;
                $display("FAIL reset_rdata: got %h want %h", rdata_o, m_rdata);
            end
            tick();
        end
        @(negedge clk);
        resetn = 1'b1;
        req    = '0;
        m_ack  = 1'b0;
        tick();
    endtask

    // Single beat to requester 2, acknowledged on its third BUSY cycle.
    task automatic test_single();
        set_len(0, 0, 0, 0);
        for (int c = 0; c < 7; c++) begin
            m_ack = (c == 3);
            req   = (c < 4) ? 4'b0100 : (c < 6) ? 4'hF : 4'h0;
            rand_data();
            @(negedge clk);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 1 || c == 3 || c == 4 || c == 5) begin
                logic [7:0] want;
                want = (c == 1) ? 8'b0100_0000 : (c == 3) ? 8'b0100_0100 :
                       (c == 4) ? 8'b0000_0000 : 8'b1000_0000;
                n_tests++;
                if ({gnt_o, ack_o} !== want) begin
                    n_fail++;
                    $display("FAIL single_gnt_ack c=%0d: got gnt=%b ack=%b want %b", c, gnt_o,
                             ack_o, want);
                end
            end
            tick();
        end
    endtask

    // All four requesting, single-beat bursts, always acknowledged.
    task automatic test_rotation();
        req   = 4'hF;
        m_ack = 1'b1;
        set_len(0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            logic [4:0] want;
            rand_data();
            @(negedge clk);
            want = (c % 2 == 0) ? 5'b0 : {4'(1 << ((c / 2) % 4)), 1'b1};
            n_tests++;
            if ({gnt_o, m_req} !== want) begin
                n_fail++;
                $display("FAIL rotation c=%0d: got gnt=%b m_req=%b want %b", c, gnt_o, m_req,
                         want);
            end
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            tick();
        end
        req = '0;
    endtask

    // Four-beat burst to requester 1 (ptr is 1), then requester 0 gets its turn.
    task automatic test_burst();
        int acks = 0;
        req   = 4'b0011;
        m_ack = 1'b1;
        set_len(0, 3, 0, 0);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) len_a[1] = 4'd0;
            if (c == 7) req = '0;
            rand_data();
            @(negedge clk);
            if (ack_o === 4'b0010) acks++;
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL burst_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 6) begin
                n_tests++;
                if (gnt_o !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL burst_next_gnt: got %b want 0001", gnt_o);
                end
            end
            tick();
        end
        n_tests++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL burst_ack_count: got %0d want 4", acks);
        end
    endtask

    // Requester 2 never acknowledged: abort after TIMEOUT BUSY cycles.
    task automatic test_timeout();
        m_ack = 1'b0;
        set_len(0, 0, 5, 0);
        for (int c = 0; c < 20; c++) begin
            req = (c < 17) ? 4'b0100 : (c == 17) ? 4'hF : 4'h0;
            rand_data();
            @(negedge clk);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 16 || c == 17 || c == 18) begin
                logic [6:0] want;
                want = (c == 16) ? 7'b0_0100_1_1 : (c == 17) ? 7'b1_0000_0_0 : 7'b0_1000_1_1;
                n_tests++;
                if ({err_o, gnt_o, m_req, busy_o} !== want) begin
                    n_fail++;
                    $display("FAIL timeout_err c=%0d: got err=%b gnt=%b m_req=%b busy=%b want %b",
                             c, err_o, gnt_o, m_req, busy_o, want);
                end
            end
            tick();
        end
    endtask

    // Requester 1 withdraws mid-burst without an acknowledge.
    task automatic test_drop();
        set_len(0, 3, 0, 0);
        for (int c = 0; c < 6; c++) begin
            req   = (c < 2) ? 4'b0010 : (c == 2) ? 4'b0000 : (c < 5) ? 4'b0111 : 4'b0000;
            m_ack = (c == 1 || c == 4);
            rand_data();
            @(negedge clk);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 3 || c == 4) begin
                logic [5:0] want;
                want = (c == 3) ? 6'b0_0_0000 : 6'b1_0_0100;
                n_tests++;
                if ({busy_o, err_o, gnt_o} !== want) begin
                    n_fail++;
                    $display("FAIL drop_idle c=%0d: got busy=%b err=%b gnt=%b want %b", c,
                             busy_o, err_o, gnt_o, want);
                end
            end
            tick();
        end
    endtask

    // Asynchronous reset during beat 2 of a four-beat burst to requester 3.
    task automatic test_reset_mid();
        req   = 4'b1000;
        m_ack = 1'b1;
        set_len(0, 0, 0, 3);
        for (int c = 0; c < 3; c++) begin
            rand_data();
            @(negedge clk);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c < 2) tick();
        end
        resetn = 1'b0;
        m_reset();
        #1;
        n_tests++;
        if ({gnt_o, ack_o, err_o, busy_o, m_req, m_we, m_addr, m_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got gnt=%b ack=%b busy=%b m_req=%b addr=%h want all zero",
                     gnt_o, ack_o, busy_o, m_req, m_addr);
        end
        tick();
        req = 4'b1010;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_first_gnt: got %b want 0010", gnt_o);
        end
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rstmid_model_after: got %h want %h", act_vec(), exp_vec());
        end
        req   = '0;
        m_ack = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int stall = 0;
        req = '0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(9) == 0) req[k] = ~req[k];
                len_a[k] = 4'($urandom_range(3));
            end
            if (stall > 0) begin
                m_ack = 1'b0;
                stall--;
            end else begin
                m_ack = ($urandom_range(2) != 0);
                if ($urandom_range(49) == 0) stall = 20;
            end
            rand_data();
            @(negedge clk);
            n_tests++;
            if (act_vec() !== exp_vec() || !$onehot0(gnt_o)) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_burst();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
